et_sng_mul: RTL and testbench

Early-termination stochastic number generator and multiplier; sits directly upstream of the progressive stochastic-to-binary converter. Latches two unsigned WIDTH-bit fractions X, Y and a precision `prec`, emits one stochastic bit per cycle for N = 2^prec cycles, and flags the final bit with `done`. The X sequence is the bit-reversed (van der Corput) counter; the Y sequence is either the scaled counter (Hammersley, uncorrelated, pz ≈ X·Y) or the same van der Corput sequence (correlated, pz = min(X,Y)). `done` lands on a power-of-two stream boundary, so the converter's done gating is directly valid.

---
 rtl/sc_pkg.sv | 26 ++
 rtl/sng_cmp.sv | 13 +
 rtl/et_sng_mul.sv | 156 +++++++++++++++
 tb/tb_et_sng_mul.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the early-termination stochastic number generator.
package sc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Widest sequence that bitrev can handle.
  localparam int BITREV_MAX = 32;

  // Width needed to hold a precision value in the range 0..width.
  function automatic int pw_of(input int width);
    return $clog2(width + 1);
  endfunction

  // Reverse the low `width` bits of v (van der Corput radical inverse).
  // Bits above `width` in the result are zero.
  function automatic logic [BITREV_MAX-1:0] bitrev(input logic [BITREV_MAX-1:0] v,
                                                   input int width);
    logic [BITREV_MAX-1:0] r;
    r = {<<{v}};
    return r >> (BITREV_MAX - width);
  endfunction

endpackage

// File: rtl/sng_cmp.sv
// Stochastic bit generator: compares an operand against one value of a
// low-discrepancy sequence. The bit is 1 when the operand exceeds the sequence value.
module sng_cmp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] op,
  input  logic [WIDTH-1:0] seq,
  output logic             sbit
);

  assign sbit = (op > seq);

endmodule

// File: rtl/et_sng_mul.sv
// Early-termination stochastic number generator and multiplier.
// Emits 2^P stochastic bits for X and Y, plus pz = px & py.
// The X sequence is the bit-reversed counter. The Y sequence is either the
// scaled counter (corr=0, product) or the same bit-reversed counter
// (corr=1, minimum).
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no stream; outputs low; ready=1
//   RUN   | bit index ctr is on the outputs; ready=1 only on the last bit
//
// The next bit index and its operands are resolved combinationally, then
// registered together with the comparator results. As a result, bit i of a
// stream accepted on cycle t appears on cycle t+1+i.
module et_sng_mul
  import sc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PW    = pw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [PW-1:0]    prec,
  input  logic             corr,
  input  logic             abort,
  output logic             valid,
  output logic             px,
  output logic             py,
  output logic             pz,
  output logic             first,
  output logic             done
);

  localparam logic [PW-1:0]  P_MAX = PW'(WIDTH);
  localparam logic [WIDTH:0] ONE   = {{WIDTH{1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH:0]   ctr;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic             corr_q;
  logic [PW-1:0]    p_q;

  logic [WIDTH:0]   cur_last;
  logic             last;
  logic             accept;

  logic             nxt_run;
  logic [WIDTH:0]   nxt_idx;
  logic [WIDTH-1:0] nxt_x;
  logic [WIDTH-1:0] nxt_y;
  logic             nxt_corr;
  logic [PW-1:0]    nxt_p;
  logic [WIDTH:0]   nxt_last;

  logic [BITREV_MAX-1:0] idx_ext;
  logic [BITREV_MAX-1:0] rx_full;
  logic [WIDTH:0]        ry_full;
  logic [WIDTH-1:0]      rx;
  logic [WIDTH-1:0]      ry;
  logic                  bit_x;
  logic                  bit_y;
  logic                  unused_ok;

  // The last index is 2^P - 1. The counter is one bit wider than the
  // sequence, so P = WIDTH fits.
  assign cur_last = (ONE << p_q) - ONE;
  assign last     = (state == RUN) && (ctr == cur_last);
  assign ready    = (state == IDLE) || last;
  assign accept   = start && ready;

  // Resolve what the next cycle carries. Abort wins over a back-to-back accept.
  always_comb begin
    nxt_run  = 1'b0;
    nxt_idx  = '0;
    nxt_x    = x_q;
    nxt_y    = y_q;
    nxt_corr = corr_q;
    nxt_p    = p_q;
    if ((state == RUN) && abort) begin
      nxt_run = 1'b0;
    end else if (accept) begin
      nxt_run  = 1'b1;
      nxt_x    = x;
      nxt_y    = y;
      nxt_corr = corr;
      nxt_p    = (prec > P_MAX) ? P_MAX : prec;
    end else if ((state == RUN) && !last) begin
      nxt_run = 1'b1;
      nxt_idx = ctr + ONE;
    end
  end

  // Build sequence values for the next index.
  // Y uses the scaled counter (Hammersley) or shares the X sequence.
  always_comb begin
    idx_ext              = '0;
    idx_ext[WIDTH-1:0]   = nxt_idx[WIDTH-1:0];
    rx_full              = bitrev(idx_ext, WIDTH);
    rx                   = rx_full[WIDTH-1:0];
    ry_full              = nxt_idx << (P_MAX - nxt_p);
    ry                   = nxt_corr ? rx : ry_full[WIDTH-1:0];
    nxt_last             = (ONE << nxt_p) - ONE;
  end

  // Upper bits are always zero. They are tied off here so the intent is explicit.
  assign unused_ok = ^{rx_full[BITREV_MAX-1:WIDTH], ry_full[WIDTH]};

  sng_cmp #(.WIDTH(WIDTH)) u_cmp_x (
    .op   (nxt_x),
    .seq  (rx),
    .sbit (bit_x)
  );

  sng_cmp #(.WIDTH(WIDTH)) u_cmp_y (
    .op   (nxt_y),
    .seq  (ry),
    .sbit (bit_y)
  );

  // FSM, counter, operand registers and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ctr    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      corr_q <= 1'b0;
      p_q    <= '0;
      valid  <= 1'b0;
      px     <= 1'b0;
      py     <= 1'b0;
      pz     <= 1'b0;
      first  <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= nxt_run ? RUN : IDLE;
      ctr    <= nxt_idx;
      x_q    <= nxt_x;
      y_q    <= nxt_y;
      corr_q <= nxt_corr;
      p_q    <= nxt_p;
      valid  <= nxt_run;
      px     <= nxt_run & bit_x;
      py     <= nxt_run & bit_y;
      pz     <= nxt_run & bit_x & bit_y;
      first  <= nxt_run & (nxt_idx == '0);
      done   <= nxt_run & (nxt_idx == nxt_last);
    end
  end

endmodule

// File: tb/tb_et_sng_mul.sv
// Scoreboard bench for et_sng_mul.
// Stimulus pushes the expected bits per stream. A negedge monitor pops and
// compares them, including the cycle on which each bit must appear.
`timescale 1ns/1ps
module tb_et_sng_mul;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          corr  = 1'b0;
  logic [W-1:0]  x     = '0;
  logic [W-1:0]  y     = '0;
  logic [PW-1:0] prec  = '0;
  logic ready, valid, px, py, pz, first, done;

  et_sng_mul #(.WIDTH(W), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ready (ready),
    .x     (x),
    .y     (y),
    .prec  (prec),
    .corr  (corr),
    .abort (abort),
    .valid (valid),
    .px    (px),
    .py    (py),
    .pz    (pz),
    .first (first),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit px, py, pz, first, done;
  } exp_t;

  typedef struct {
    int ox, oy, oz;
    bit chk_z;
  } sum_t;

  exp_t q[$];
  sum_t sq[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Radical inverse of i over W bits, built up digit by digit.
  function automatic int vdc(input int i);
    int r = 0;
    for (int k = 0; k < W; k++)
      if (((i >> k) & 1) == 1) r += 1 << (W - 1 - k);
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1. Asserts start for one cycle and records expectations.
  // nbits < 0 means the full stream is expected.
  task automatic launch(input int xv, input int yv, input int pv, input int cv,
                        input int nbits, output int n);
    int p, s, base, lim, rx, ry;
    exp_t e;
    sum_t sm;
    check("ready_at_start", ready, 1);
    start = 1'b1;
    x     = 8'(xv);
    y     = 8'(yv);
    prec  = 4'(pv);
    corr  = 1'(cv);
    p     = imin(pv, W);
    n     = 1 << p;
    s     = 1 << (W - p);
    base  = cyc + 1;
    lim   = (nbits < 0) ? n : nbits;
    for (int i = 0; i < lim; i++) begin
      rx      = vdc(i);
      ry      = (cv != 0) ? rx : i * s;
      e.cyc   = base + i;
      e.px    = (xv > rx);
      e.py    = (yv > ry);
      e.pz    = e.px && e.py;
      e.first = (i == 0);
      e.done  = (i == n - 1);
      q.push_back(e);
    end
    if (nbits < 0) begin
      sm.ox    = (xv + s - 1) / s;
      sm.oy    = (yv + s - 1) / s;
      sm.oz    = imin(sm.ox, sm.oy);
      sm.chk_z = (cv != 0);
      sq.push_back(sm);
    end
    step(1);
    start = 1'b0;
    x     = 8'($urandom);
    y     = 8'($urandom);
    prec  = 4'($urandom);
    corr  = 1'($urandom);
  endtask

  task automatic run_full(input int xv, input int yv, input int pv, input int cv);
    int n;
    launch(xv, yv, pv, cv, -1, n);
    step(n);
  endtask

  // Monitor: compares every emitted bit against the scoreboard and counts ones.
  int   cx = 0, cy = 0, cz = 0;
  exp_t me;
  sum_t ms;
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_bit", 1, 0);
      end else begin
        me = q.pop_front();
        check("bit_cycle", cyc, me.cyc);
        check("px", px, me.px);
        check("py", py, me.py);
        check("pz", pz, me.pz);
        check("first", first, me.first);
        check("done", done, me.done);
      end
      if (first === 1'b1) begin
        cx = 0; cy = 0; cz = 0;
      end
      cx += int'(px);
      cy += int'(py);
      cz += int'(pz);
      if (done === 1'b1) begin
        if (sq.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          ms = sq.pop_front();
          check("ones_px", cx, ms.ox);
          check("ones_py", cy, ms.oy);
          if (ms.chk_z) check("ones_pz_min", cz, ms.oz);
        end
      end
    end else begin
      check("idle_outputs_low", {27'd0, valid, px, py, pz, first, done}, 0);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, n2, xv, yv, pv, cv;
    #1 rst_n = 1'b0;
    #1;
    check("reset_ready", ready, 1);
    check("reset_outputs", {valid, px, py, pz, first, done}, 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Basic product and min streams.
    launch(8'h80, 8'h80, 2, 0, -1, n);
    step(n - 1);
    check("ready_on_last_bit", ready, 1);
    step(1);
    check("ready_after_stream", ready, 1);
    run_full(8'hC0, 8'h40, 2, 1);

    // Single-bit stream, and clamped precision.
    run_full(8'h01, 8'h00, 0, 0);
    run_full(8'h01, 8'h80, 15, 0);

    // Back-to-back: the new stream starts right after done.
    launch(8'h80, 8'h40, 2, 0, -1, n);
    step(n - 1);
    launch(8'hFF, 8'h33, 2, 1, -1, n2);
    step(n2);

    // Abort at bit 5. A start issued on the abort cycle is ignored.
    launch(8'hA5, 8'h5A, 4, 0, 6, n);
    step(5);
    abort = 1'b1; start = 1'b1; x = 8'hFF; y = 8'hFF; prec = 4'd2;
    step(1);
    abort = 1'b0; start = 1'b0;
    check("ready_after_abort", ready, 1);
    check("valid_after_abort", valid, 0);
    step(2);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_in_idle_valid", valid, 0);
    run_full(8'h37, 8'hC8, 3, 0);

    // A start while busy is ignored, and its operands are not sampled.
    launch(8'h60, 8'h90, 3, 1, -1, n);
    step(2);
    start = 1'b1; x = 8'hFF; y = 8'hFF; prec = 4'd1; corr = 1'b0;
    step(1);
    start = 1'b0;
    step(n - 3);

    // Asynchronous reset during bit 2.
    launch(8'h99, 8'h66, 3, 0, 2, n);
    step(1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {valid, px, py, pz, first, done}, 0);
    check("midreset_ready", ready, 1);
    step(1);
    rst_n = 1'b1;
    step(1);
    run_full(8'hE1, 8'h1E, 5, 1);

    // Random streams, some back-to-back.
    for (int r = 0; r < 1000; r++) begin
      xv = $urandom_range(0, 255);
      yv = $urandom_range(0, 255);
      pv = (r % 50 == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6);
      cv = $urandom_range(0, 1);
      launch(xv, yv, pv, cv, -1, n);
      step(n - 1);
      if ($urandom_range(0, 1) == 0) step(1 + $urandom_range(0, 2));
    end
    step(5);
    check("queue_drained", q.size(), 0);
    check("summaries_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
